// File: rtl/daq_fx2_streamer.sv
// Packet-aligning bridge from the DAQ FIFO (FWFT read side) to the FX2 slave FIFO.
// Hunts for the preamble, checks packet-counter continuity, forwards whole packets.
module daq_fx2_streamer #(
  parameter logic [15:0] PREAMBLE      = 16'hAAAA,
  parameter int          PAYLOAD_WORDS = 64,
  parameter bit          PKTEND_EN     = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic [15:0] fifo_dout_i,
  input  logic        fifo_empty_i,
  output logic        fifo_rd_en_o,
  input  logic        fx2_full_n_i,
  output logic [15:0] fx2_fd_o,
  output logic        fx2_slwr_n_o,
  output logic        fx2_pktend_n_o,
  output logic        pkt_done_o,
  output logic [15:0] drop_cnt_o,
  output logic [15:0] seq_err_cnt_o,
  output logic        synced_o
);
  localparam int PCW = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam logic [PCW-1:0] LAST = PCW'(PAYLOAD_WORDS - 1);

  typedef enum logic [2:0] {S_HUNT, S_HDR, S_CNT, S_PAY, S_END} state_t;

  state_t         state;
  logic [15:0]    expected;
  logic           seq_valid;
  logic [PCW-1:0] pay_cnt;

  logic avail, fwd, is_pre, xfer, hunt_pop;

  assign avail    = en_i & ~fifo_empty_i;
  assign fwd      = (state == S_HDR) | (state == S_CNT) | (state == S_PAY);
  assign xfer     = avail & fx2_full_n_i & fwd;
  assign is_pre   = (fifo_dout_i == PREAMBLE);
  // A preamble seen while hunting stays at the FIFO head so HDR can forward it.
  assign hunt_pop = (state == S_HUNT) & avail & ~is_pre;

  assign fifo_rd_en_o = ~reset_i & (xfer | hunt_pop);
  assign synced_o     = (state != S_HUNT);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state          <= S_HUNT;
      expected       <= 16'h0000;
      seq_valid      <= 1'b0;
      pay_cnt        <= '0;
      fx2_fd_o       <= 16'h0000;
      fx2_slwr_n_o   <= 1'b1;
      fx2_pktend_n_o <= 1'b1;
      pkt_done_o     <= 1'b0;
      drop_cnt_o     <= 16'h0000;
      seq_err_cnt_o  <= 16'h0000;
    end else begin
      fx2_slwr_n_o   <= ~xfer;
      fx2_pktend_n_o <= 1'b1;
      pkt_done_o     <= 1'b0;
      if (xfer) fx2_fd_o <= fifo_dout_i;

      case (state)
        S_HUNT: begin
          if (hunt_pop) begin
            if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
          end else if (avail) begin
            state <= S_HDR;
          end
        end
        S_HDR: if (xfer) state <= S_CNT;
        S_CNT: begin
          if (xfer) begin
            if (seq_valid && (fifo_dout_i != expected) && (seq_err_cnt_o != 16'hFFFF))
              seq_err_cnt_o <= seq_err_cnt_o + 16'd1;
            expected  <= fifo_dout_i + 16'd1;
            seq_valid <= 1'b1;
            pay_cnt   <= '0;
            state     <= S_PAY;
          end
        end
        S_PAY: begin
          if (xfer) begin
            pay_cnt <= pay_cnt + PCW'(1);
            if (pay_cnt == LAST) begin
              pkt_done_o <= 1'b1;
              state      <= PKTEND_EN ? S_END : S_HUNT;
            end
          end
        end
        S_END: begin
          // No write is issued here, so the pulse never coincides with SLWR.
          if (fx2_full_n_i) begin
            fx2_pktend_n_o <= 1'b0;
            state          <= S_HUNT;
          end
        end
        default: state <= S_HUNT;
      endcase
    end
  end
endmodule

// File: tb/tb_daq_fx2_streamer.sv
// Directed bench for daq_fx2_streamer: queue-modelled FWFT FIFO in, FX2 write log out.
module tb_daq_fx2_streamer;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        en_i = 1'b0;
  logic [15:0] fifo_dout_i = 16'h0000;
  logic        fifo_empty_i = 1'b1;
  logic        fifo_rd_en_o;
  logic        fx2_full_n_i = 1'b1;
  logic [15:0] fx2_fd_o;
  logic        fx2_slwr_n_o;
  logic        fx2_pktend_n_o;
  logic        pkt_done_o;
  logic [15:0] drop_cnt_o;
  logic [15:0] seq_err_cnt_o;
  logic        synced_o;

  daq_fx2_streamer dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i),
    .fifo_dout_i(fifo_dout_i), .fifo_empty_i(fifo_empty_i), .fifo_rd_en_o(fifo_rd_en_o),
    .fx2_full_n_i(fx2_full_n_i), .fx2_fd_o(fx2_fd_o), .fx2_slwr_n_o(fx2_slwr_n_o),
    .fx2_pktend_n_o(fx2_pktend_n_o), .pkt_done_o(pkt_done_o), .drop_cnt_o(drop_cnt_o),
    .seq_err_cnt_o(seq_err_cnt_o), .synced_o(synced_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [15:0] q[$];
  logic [15:0] wr_q[$];
  logic [15:0] exp_q[$];
  int done_cnt = 0;
  int pe_cnt = 0;
  int ovl_cnt = 0;
  bit stall_empty = 1'b0;

  // FIFO model: pop on the edge, present the new head on the falling edge.
  always @(posedge clk_i) if (fifo_rd_en_o && q.size() > 0) void'(q.pop_front());

  always @(negedge clk_i) begin
    fifo_empty_i <= stall_empty || (q.size() == 0);
    fifo_dout_i  <= (q.size() > 0) ? q[0] : 16'h0000;
    if (!fx2_slwr_n_o) wr_q.push_back(fx2_fd_o);
    if (!fx2_pktend_n_o) pe_cnt <= pe_cnt + 1;
    if (pkt_done_o) done_cnt <= done_cnt + 1;
    if (!fx2_slwr_n_o && !fx2_pktend_n_o) ovl_cnt <= ovl_cnt + 1;
  end

  function automatic logic [15:0] pw(input logic [15:0] cnt, input int i);
    logic [7:0] lo;
    lo = 8'(i);
    return (i == 10) ? 16'hAAAA : {cnt[7:0] ^ 8'h5A, lo};
  endfunction

  task automatic push_pkt(input logic [15:0] cnt);
    q.push_back(16'hAAAA); exp_q.push_back(16'hAAAA);
    q.push_back(cnt);      exp_q.push_back(cnt);
    for (int i = 0; i < 64; i++) begin
      q.push_back(pw(cnt, i)); exp_q.push_back(pw(cnt, i));
    end
  endtask

  task automatic wait_writes(input int base, input int n, input int budget);
    int c = 0;
    while ((wr_q.size() - base < n) && c < budget) begin
      @(negedge clk_i); #1; c++;
    end
    if (wr_q.size() - base < n) begin
      checks++; errors++;
      $display("FAIL timeout: %0d writes seen, %0d required", wr_q.size() - base, n);
    end
  endtask

  task automatic run_writes(input int base, input int n);
    wait_writes(base, n, 600);
    repeat (4) @(negedge clk_i);
    #1;
  endtask

  task automatic check_stream(input string name, input int base);
    int bad = -1;
    checks++;
    for (int k = 0; k < exp_q.size() && bad < 0; k++)
      if (base + k >= wr_q.size() || wr_q[base + k] !== exp_q[k]) bad = k;
    if (bad < 0 && wr_q.size() - base != exp_q.size()) bad = exp_q.size();
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: %0d writes, required %0d; first bad index %0d got %h want %h", name,
               wr_q.size() - base, exp_q.size(), bad,
               (base + bad < wr_q.size()) ? wr_q[base + bad] : 16'hxxxx,
               (bad < exp_q.size()) ? exp_q[bad] : 16'hxxxx);
    end
  endtask

  task automatic do_reset;
    @(negedge clk_i); #1;
    reset_i = 1'b1; q.delete(); exp_q.delete();
    stall_empty = 1'b0; fx2_full_n_i = 1'b1; en_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i); #1;
  endtask

  task automatic test_reset;
    do_reset();
    reset_i = 1'b1; #1;
    checks++;
    if ({fx2_fd_o, fx2_slwr_n_o, fx2_pktend_n_o, pkt_done_o, drop_cnt_o, seq_err_cnt_o, synced_o, fifo_rd_en_o}
        !== {16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: fd=%h slwr=%b pe=%b done=%b drop=%h seq=%h sync=%b rd=%b", fx2_fd_o,
               fx2_slwr_n_o, fx2_pktend_n_o, pkt_done_o, drop_cnt_o, seq_err_cnt_o, synced_o, fifo_rd_en_o);
    end
    #1 reset_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    int base, d0, p0, o0;
    do_reset();
    base = wr_q.size(); d0 = done_cnt; p0 = pe_cnt; o0 = ovl_cnt;
    push_pkt(16'h0005); push_pkt(16'h0006);
    run_writes(base, 132);
    check_stream("b2b_stream", base);
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_pkt_done: got %0d want 2", done_cnt - d0); end
    checks++; if (pe_cnt - p0 !== 2) begin errors++; $display("FAIL b2b_pktend: got %0d want 2", pe_cnt - p0); end
    checks++; if (seq_err_cnt_o !== 16'd0) begin errors++; $display("FAIL b2b_seq: got %0d want 0", seq_err_cnt_o); end
    checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL b2b_drop: got %0d want 0", drop_cnt_o); end
    checks++; if (ovl_cnt - o0 !== 0) begin errors++; $display("FAIL b2b_overlap: got %0d want 0", ovl_cnt - o0); end
  endtask

  task automatic test_junk;
    int base;
    do_reset();
    base = wr_q.size();
    q.push_back(16'h1234); q.push_back(16'hAAAB); q.push_back(16'h0000);
    push_pkt(16'h0007);
    run_writes(base, 66);
    check_stream("junk_stream", base);
    checks++; if (drop_cnt_o !== 16'd3) begin errors++; $display("FAIL junk_drop: got %0d want 3", drop_cnt_o); end
  endtask

  task automatic test_seq_wrap;
    int base;
    do_reset();
    base = wr_q.size();
    push_pkt(16'hFFFF); push_pkt(16'h0000);
    run_writes(base, 132);
    checks++; if (seq_err_cnt_o !== 16'd0) begin errors++; $display("FAIL wrap_seq: got %0d want 0", seq_err_cnt_o); end
    push_pkt(16'h0002);
    run_writes(base, 198);
    checks++; if (seq_err_cnt_o !== 16'd1) begin errors++; $display("FAIL gap_seq: got %0d want 1", seq_err_cnt_o); end
    check_stream("seq_stream", base);
  endtask

  task automatic test_full_stall;
    int base, n0;
    do_reset();
    base = wr_q.size();
    push_pkt(16'h0009);
    wait_writes(base, 22, 200);
    fx2_full_n_i = 1'b0;
    n0 = wr_q.size();
    repeat (10) @(negedge clk_i);
    #1;
    checks++; if (wr_q.size() !== n0) begin errors++; $display("FAIL full_frozen: got %0d writes want %0d", wr_q.size(), n0); end
    fx2_full_n_i = 1'b1;
    run_writes(base, 66);
    check_stream("full_stream", base);
  endtask

  task automatic test_empty_stall;
    int base;
    do_reset();
    base = wr_q.size();
    push_pkt(16'h000A);
    wait_writes(base, 40, 200);
    stall_empty = 1'b1;
    repeat (7) @(negedge clk_i);
    #1 stall_empty = 1'b0;
    run_writes(base, 66);
    check_stream("empty_stream", base);
  endtask

  task automatic test_reset_mid;
    int base, d0;
    do_reset();
    push_pkt(16'h0014);
    wait_writes(wr_q.size(), 32, 200);
    reset_i = 1'b1; #1;
    checks++;
    if ({fx2_fd_o, fx2_slwr_n_o, fx2_pktend_n_o, pkt_done_o, drop_cnt_o, seq_err_cnt_o, synced_o, fifo_rd_en_o}
        !== {16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_values: fd=%h slwr=%b pe=%b done=%b drop=%h seq=%h sync=%b rd=%b", fx2_fd_o,
               fx2_slwr_n_o, fx2_pktend_n_o, pkt_done_o, drop_cnt_o, seq_err_cnt_o, synced_o, fifo_rd_en_o);
    end
    q.delete(); exp_q.delete();
    repeat (2) @(negedge clk_i);
    #1 reset_i = 1'b0;
    base = wr_q.size(); d0 = done_cnt;
    push_pkt(16'h0050);
    run_writes(base, 66);
    check_stream("midreset_stream", base);
    checks++; if (seq_err_cnt_o !== 16'd0) begin errors++; $display("FAIL midreset_seq: got %0d want 0", seq_err_cnt_o); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL midreset_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_en_pause;
    int base, bad;
    do_reset();
    base = wr_q.size();
    push_pkt(16'h001E);
    wait_writes(base, 1, 100);
    en_i = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk_i); #1;
      if (fifo_rd_en_o !== 1'b0 || fx2_slwr_n_o !== 1'b1 || synced_o !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL en_hold: %0d active cycles want 0", bad); end
    checks++; if (wr_q.size() - base !== 1) begin errors++; $display("FAIL en_count: got %0d writes want 1", wr_q.size() - base); end
    en_i = 1'b1;
    run_writes(base, 66);
    check_stream("en_stream", base);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_junk();
    test_seq_wrap();
    test_full_stall();
    test_empty_stall();
    test_reset_mid();
    test_en_pause();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
